// File: rtl/npu_pkg.sv
// Shared NPU image constants and the result streamer state type.
// Used by the NPU top, the VGA path and the result streamer.
package npu_pkg;

    localparam int IMG_W      = 400;
    localparam int IMG_H      = 400;
    localparam int TILE       = 10;
    localparam int IMG_PIXELS = IMG_W * IMG_H;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_ISSUE,
        RS_WAIT,
        RS_PRESENT,
        RS_FIN
    } rs_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Pixel position counters yielding a RAM address in raster or tile order.
// Latency: addr/is_last are combinational from the counters; advance takes effect next cycle.
// Backpressure: none internally; the owner holds advance low to stall.
module tile_addr_gen
    import npu_pkg::*;
#(
    parameter int IMG_W = npu_pkg::IMG_W,
    parameter int IMG_H = npu_pkg::IMG_H,
    parameter int TILE  = npu_pkg::TILE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    input  logic        mode,
    output logic [18:0] addr,
    output logic        is_last
);

    localparam logic [9:0] X_MAX  = 10'(IMG_W - 1);
    localparam logic [9:0] Y_MAX  = 10'(IMG_H - 1);
    localparam logic [9:0] T_MAX  = 10'(TILE - 1);
    localparam logic [9:0] TX_MAX = 10'(IMG_W / TILE - 1);
    localparam logic [9:0] TY_MAX = 10'(IMG_H / TILE - 1);

    logic [9:0]  x, y, c, r, tx, ty;
    logic [18:0] raster_addr, tile_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0; y <= '0; c <= '0; r <= '0; tx <= '0; ty <= '0;
        end else if (clear) begin
            x <= '0; y <= '0; c <= '0; r <= '0; tx <= '0; ty <= '0;
        end else if (advance) begin
            if (mode) begin
                // col -> row -> tile x -> tile y, same walk as the writer
                if (c != T_MAX) begin
                    c <= c + 10'd1;
                end else begin
                    c <= '0;
                    if (r != T_MAX) begin
                        r <= r + 10'd1;
                    end else begin
                        r <= '0;
                        if (tx != TX_MAX) begin
                            tx <= tx + 10'd1;
                        end else begin
                            tx <= '0;
                            ty <= ty + 10'd1;
                        end
                    end
                end
            end else begin
                if (x != X_MAX) begin
                    x <= x + 10'd1;
                end else begin
                    x <= '0;
                    y <= y + 10'd1;
                end
            end
        end
    end

    assign raster_addr = 19'(y) * 19'(IMG_W) + 19'(x);
    assign tile_addr   = (19'(ty) * 19'(TILE) + 19'(r)) * 19'(IMG_W)
                       + 19'(tx) * 19'(TILE) + 19'(c);
    assign addr        = mode ? tile_addr : raster_addr;
    assign is_last     = mode ? (tx == TX_MAX && ty == TY_MAX && r == T_MAX && c == T_MAX)
                              : (x == X_MAX && y == Y_MAX);

endmodule

// File: rtl/ram_result_streamer.sv
// Reads the processed-image RAM back and streams one byte per valid/ready handshake.
// Latency: RAM_LAT+2 cycles per byte with m_ready held high.
// Backpressure: m_ready low stalls in PRESENT with data, address and counters frozen.
module ram_result_streamer
    import npu_pkg::*;
#(
    parameter int IMG_W   = npu_pkg::IMG_W,
    parameter int IMG_H   = npu_pkg::IMG_H,
    parameter int TILE    = npu_pkg::TILE,
    parameter int RAM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tile_mode,
    output logic [18:0] ram_addr,
    input  logic [7:0]  ram_q,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done,
    output logic [17:0] rd_count
);

    localparam logic [3:0] LAT_INIT = 4'(RAM_LAT - 1);

    rs_state_t   state;
    logic [3:0]  lat_cnt;
    logic        mode_q;
    logic        gen_clear, gen_adv, gen_last;
    logic [18:0] gen_addr;

    assign gen_clear = (state == RS_IDLE) && start;
    assign gen_adv   = (state == RS_PRESENT) && m_ready && !m_last;

    tile_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .TILE  (TILE)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (gen_clear),
        .advance (gen_adv),
        .mode    (mode_q),
        .addr    (gen_addr),
        .is_last (gen_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RS_IDLE;
            lat_cnt  <= '0;
            mode_q   <= 1'b0;
            ram_addr <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_count <= '0;
        end else begin
            case (state)
                RS_IDLE: begin
                    if (start) begin
                        mode_q   <= tile_mode;
                        rd_count <= '0;
                        busy     <= 1'b1;
                        state    <= RS_ISSUE;
                    end
                end
                RS_ISSUE: begin
                    ram_addr <= gen_addr;
                    rd_count <= rd_count + 18'd1;
                    lat_cnt  <= LAT_INIT;
                    state    <= RS_WAIT;
                end
                RS_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        m_data  <= ram_q;
                        m_valid <= 1'b1;
                        m_last  <= gen_last;
                        state   <= RS_PRESENT;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RS_PRESENT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (m_last) begin
                            // done is visible during FIN so a start in that cycle is dropped
                            done  <= 1'b1;
                            state <= RS_FIN;
                        end else begin
                            state <= RS_ISSUE;
                        end
                    end
                end
                RS_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= RS_IDLE;
                end
                default: state <= RS_IDLE;
            endcase
        end
    end

endmodule
